pc_unit: RTL and testbench

Program-counter and return-address-stack stage of the single-cycle CPU, directly upstream of instruction memory and the control unit. Each clock it selects the next PC from the control unit's sequencing strobes (`s_inc`, `s_rel`, `s_bk`, `s_ret`): increment, absolute jump, relative jump, subroutine call or return. It also maintains a bounded LIFO of return addresses with occupancy and error status.

---
 rtl/pc_unit_if.sv | 31 +++
 rtl/pc_unit.sv | 117 +++++++++++
 tb/tb_pc_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Control-unit <-> PC stage bundle: sequencing strobes and jump operands in,
// registered PC and return-stack status out.
interface pc_unit_if #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 10,
  parameter int DEPTH = 8
);
  localparam int SP_W = $clog2(DEPTH) + 1;

  logic             s_inc;
  logic             s_rel;
  logic             s_bk;
  logic             s_ret;
  logic [PC_W-1:0]  target;
  logic [OFF_W-1:0] rel_off;
  logic [PC_W-1:0]  pc;
  logic [SP_W-1:0]  sp_count;
  logic             stk_empty;
  logic             stk_full;
  logic             stk_err;

  modport master (
    output s_inc, s_rel, s_bk, s_ret, target, rel_off,
    input  pc, sp_count, stk_empty, stk_full, stk_err
  );

  modport slave (
    input  s_inc, s_rel, s_bk, s_ret, target, rel_off,
    output pc, sp_count, stk_empty, stk_full, stk_err
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with bounded return-address stack.
// Define PC_STACK_WRAP_EN to make a call on a full stack overwrite the oldest entry.
module pc_unit #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 10,
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  pc_unit_if.slave  bus
);
  localparam int SP_W  = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  if (OFF_W > PC_W) begin : g_bad_off_w
    $error("pc_unit: OFF_W must not exceed PC_W");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_unit: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    OP_INC,
    OP_REL,
    OP_JMP,
    OP_CALL,
    OP_RET
  } op_e;

  op_e              op;
  logic [PC_W-1:0]  pc_q, pc_d, pc_plus1, rel_ext;
  logic [SP_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             err_q, err_d;
  logic             push;
  logic             empty, full;
  logic [PC_W-1:0]  stack [DEPTH];
  logic [PC_W-1:0]  top;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == SP_W'(DEPTH));
  assign pc_plus1 = pc_q + PC_W'(1);
  assign rel_ext  = PC_W'($signed(bus.rel_off));
  // ptr_q always names the next free slot; in wrap mode it runs circularly so
  // the slot below it is the most recent push even after overwrites.
  assign top      = stack[ptr_q - PTR_W'(1)];

  always_comb begin
    op = OP_INC;
    if (bus.s_ret)       op = OP_RET;
    else if (bus.s_bk)   op = OP_CALL;
    else if (!bus.s_inc) op = OP_JMP;
    else if (bus.s_rel)  op = OP_REL;
  end

  always_comb begin
    pc_d  = pc_plus1;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    err_d = err_q;
    push  = 1'b0;
    case (op)
      OP_RET: begin
        if (empty) begin
          err_d = 1'b1;
        end else begin
          pc_d  = top;
          cnt_d = cnt_q - SP_W'(1);
          ptr_d = ptr_q - PTR_W'(1);
        end
      end
      OP_CALL: begin
        pc_d = bus.target;
        if (!full) begin
          push  = 1'b1;
          cnt_d = cnt_q + SP_W'(1);
          ptr_d = ptr_q + PTR_W'(1);
        end else begin
`ifdef PC_STACK_WRAP_EN
          push  = 1'b1;
          ptr_d = ptr_q + PTR_W'(1);
`else
          err_d = 1'b1;
`endif
        end
      end
      OP_JMP:  pc_d = bus.target;
      OP_REL:  pc_d = pc_q + rel_ext;
      default: pc_d = pc_plus1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  // Stack contents survive reset; only the pointer/count define validity.
  always_ff @(posedge clk) begin
    if (!reset && push) stack[ptr_q] <= pc_plus1;
  end

  assign bus.pc        = pc_q;
  assign bus.sp_count  = cnt_q;
  assign bus.stk_empty = empty;
  assign bus.stk_full  = full;
  assign bus.stk_err   = err_q;
endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a behavioural model predicts each cycle's
// outputs, and a negedge checker compares them against the DUT.
module tb_pc_unit;
  localparam int PC_W  = 10;
  localparam int OFF_W = 10;
  localparam int DEPTH = 8;
  localparam int SP_W  = $clog2(DEPTH) + 1;

  typedef struct {
    logic [PC_W-1:0] pc;
    int              cnt;
    logic            err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_unit_if #(.PC_W(PC_W), .OFF_W(OFF_W), .DEPTH(DEPTH)) bus ();
  pc_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  exp_t        sb[$];
  int unsigned cyc_idx  = 0;

  // model state
  logic [PC_W-1:0] m_pc  = '0;
  logic            m_err = 1'b0;
  logic [PC_W-1:0] m_stk[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check($sformatf("pc@%0d", cyc_idx), 32'(bus.pc), 32'(e.pc));
      check($sformatf("sp_count@%0d", cyc_idx), 32'(bus.sp_count), 32'(e.cnt));
      check($sformatf("stk_empty@%0d", cyc_idx), 32'(bus.stk_empty), 32'(e.cnt == 0));
      check($sformatf("stk_full@%0d", cyc_idx), 32'(bus.stk_full), 32'(e.cnt == DEPTH));
      check($sformatf("stk_err@%0d", cyc_idx), 32'(bus.stk_err), 32'(e.err));
      cyc_idx++;
    end
  end

  // One clock: drive inputs, advance the model, push its prediction after the edge.
  task automatic cyc(input logic r, input logic inc, input logic rel, input logic bk,
                     input logic ret, input logic [PC_W-1:0] tgt, input logic [OFF_W-1:0] off);
    exp_t e;
    reset = r; bus.s_inc = inc; bus.s_rel = rel; bus.s_bk = bk; bus.s_ret = ret;
    bus.target = tgt; bus.rel_off = off;
    if (r) begin
      m_pc = '0; m_err = 1'b0; m_stk.delete();
    end else if (ret) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_pc = m_pc + 1'b1; m_err = 1'b1; end
    end else if (bk) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(m_pc + 1'b1);
      else begin
`ifdef PC_STACK_WRAP_EN
        void'(m_stk.pop_front());
        m_stk.push_back(m_pc + 1'b1);
`else
        m_err = 1'b1;
`endif
      end
      m_pc = tgt;
    end else if (!inc) m_pc = tgt;
    else if (rel)      m_pc = m_pc + PC_W'($signed(off));
    else               m_pc = m_pc + 1'b1;
    e.pc = m_pc; e.cnt = m_stk.size(); e.err = m_err;
    @(posedge clk);
    #1;
    sb.push_back(e);
  endtask

  task automatic inc();                       cyc(0, 1, 0, 0, 0, '0, '0);  endtask
  task automatic jmp(input logic [PC_W-1:0] t); cyc(0, 0, 0, 0, 0, t, '0);   endtask
  task automatic call(input logic [PC_W-1:0] t); cyc(0, 1, 0, 1, 0, t, '0);  endtask
  task automatic ret();                       cyc(0, 1, 0, 0, 1, '0, '0);  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cyc(1, 1, 0, 0, 0, '0, '0);
    cyc(1, 1, 0, 0, 0, '0, '0);
    repeat (5) inc();

    jmp(10'h3F0);
    cyc(0, 1, 1, 0, 0, '0, 10'h3FE);
    cyc(0, 1, 1, 0, 0, '0, 10'h005);
    jmp(10'h3FF);
    inc();

    jmp(10'h010);
    call(10'h100);
    call(10'h200);
    ret();
    ret();

    jmp(10'h040);
    for (int i = 0; i < DEPTH + 1; i++) call(PC_W'(10'h080 + 16 * i));
    for (int i = 0; i < DEPTH; i++) ret();

    cyc(1, 1, 0, 0, 0, '0, '0);
    jmp(10'h020);
    ret();
    call(10'h300);
    ret();
    inc();

    cyc(0, 1, 0, 0, 0, '0, '0);
    call(10'h150);
    cyc(1, 1, 0, 1, 0, 10'h2AA, '0);
    ret();

    cyc(1, 1, 0, 0, 0, '0, '0);
    for (int i = 0; i < 60; i++) begin
      cyc(($urandom_range(0, 29) == 0), 1'($urandom), 1'($urandom),
          1'($urandom), ($urandom_range(0, 3) == 0),
          PC_W'($urandom), OFF_W'($urandom));
    end

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
